mem_arbiter: RTL

Memory-side responder for the instruction and data caches. Accepts read requests from the icache (iREN/iaddr) and read/write requests from the dcache (dREN/dWEN/daddr/dstore), grants one at a time to the single-port RAM, and returns iwait/dwait and iload/dload. Data requests have priority over instruction requests. A streak counter guarantees instruction fetches are never starved.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: memory-side responder for the icache and dcache.
// Grants one requester at a time to a single-port RAM. Data requests win over
// instruction requests, but after STARVE_LIMIT consecutive data completions
// with an instruction fetch pending, the fetch is forced through.
//
// Ports:
//   CLK, nRST               clock (rising edge), async active-low reset
//   iREN, iaddr             icache read request / word address
//   iwait, iload            icache handshake (0 = done this cycle) / read data
//   dREN, dWEN              dcache read / write request (write wins)
//   daddr, dstore           dcache word address / write data
//   dwait, dload            dcache handshake (0 = done this cycle) / read data
//   ramREN, ramWEN          RAM read / write enables
//   ramaddr, ramstore       RAM address / write data (driven from latches only)
//   ramload, ramstate       RAM read data / status (FREE, BUSY, ACCESS, ERROR)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [1:0]    state, state_nxt;
  logic          op_wr;
  logic [31:0]   addr_q, store_q;
  logic [SW-1:0] dstreak;

  logic d_req, d_go, i_done, d_done, grant;

  assign d_req = dREN | dWEN;
  // A data request yields only when a fetch is pending and the streak is full.
  assign d_go  = d_req && !(iREN && (dstreak == LIM));
  assign grant = (state == IGRANT) || (state == DGRANT);

  always_comb begin
    state_nxt = state;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (state)
      IDLE: begin
        if (d_go)      state_nxt = DGRANT;
        else if (iREN) state_nxt = IGRANT;
      end
      // Dropping the request aborts even if the RAM answers in the same cycle:
      // the owner is no longer waiting for the result.
      IGRANT: begin
        if (!iREN) state_nxt = IDLE;
        else if (ramstate == RAM_ACCESS) begin
          state_nxt = IDLE;
          i_done    = 1'b1;
        end
      end
      DGRANT: begin
        if (!d_req) state_nxt = IDLE;
        else if (ramstate == RAM_ACCESS) begin
          state_nxt = IDLE;
          d_done    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      dstreak <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (d_go) begin
          addr_q  <= daddr;
          store_q <= dstore;
          op_wr   <= dWEN;
        end else if (iREN) begin
          addr_q  <= iaddr;
          store_q <= '0;
          op_wr   <= 1'b0;
        end
        if (!iREN) dstreak <= '0;
      end
      if (i_done) dstreak <= '0;
      else if (d_done && iREN && (dstreak != LIM)) dstreak <= dstreak + 1'b1;
    end
  end

  // RAM side follows the latches only, so requester changes mid-grant are ignored.
  assign ramREN   = grant && !op_wr;
  assign ramWEN   = grant && op_wr;
  assign ramaddr  = grant ? addr_q : '0;
  assign ramstore = (grant && op_wr) ? store_q : '0;

  assign iwait = !i_done;
  assign iload = i_done ? ramload : '0;
  assign dwait = !d_done;
  assign dload = (d_done && !op_wr) ? ramload : '0;

endmodule
